// File: rtl/io_frame_sink.sv
// io_frame_sink: launches io_tx_controller, then re-presents its gapless byte stream as framed pixels (row/col, sof/eol/eof, done, err).
// Latency: tx_en one cycle after start; each tx_dout sample appears on pix_* one cycle later; done one cycle after the last pixel.
// Backpressure: none, the stream cannot be stalled; a tx_busy drop mid-frame aborts with sticky err. Checksum option: IO_FRAME_SINK_CKSUM_EN.
module io_frame_sink #(
    parameter int TX_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic [7:0]  nrows_i,
    input  logic [7:0]  ncols_i,
    input  logic [7:0]  tx_dout_i,
    input  logic        tx_busy_i,
    output logic        tx_en_o,
    output logic        busy_o,
    output logic        pix_valid_o,
    output logic [7:0]  pix_data_o,
    output logic [7:0]  row_o,
    output logic [7:0]  col_o,
    output logic        sof_o,
    output logic        eol_o,
    output logic        eof_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] cksum_o
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, STREAM, FIN} state_t;

    localparam logic [3:0] WAIT_LOAD = (TX_LATENCY > 1) ? 4'(TX_LATENCY - 2) : 4'd0;

    state_t      state_q;
    logic [7:0]  nrows_q, ncols_q;
    logic [7:0]  row_cnt_q, col_cnt_q;
    logic [3:0]  wait_q;
    logic        tx_en_q, busy_q, pix_valid_q, sof_q, eol_q, eof_q, done_q, err_q;
    logic [7:0]  pix_data_q, row_q, col_q;

    logic        accept;
    logic        row_end;
    logic        last_px;
    logic        emit;

    assign accept  = start_i && (nrows_i != 8'd0) && (ncols_i != 8'd0);
    assign row_end = (col_cnt_q == ncols_q - 8'd1);
    assign last_px = row_end && (row_cnt_q == nrows_q - 8'd1);
    // The final byte is taken even if tx_busy has already fallen with it.
    assign emit    = tx_busy_i || last_px;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            nrows_q     <= 8'd0;
            ncols_q     <= 8'd0;
            row_cnt_q   <= 8'd0;
            col_cnt_q   <= 8'd0;
            wait_q      <= 4'd0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= 8'd0;
            row_q       <= 8'd0;
            col_q       <= 8'd0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_en_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (accept) begin
                            nrows_q   <= nrows_i;
                            ncols_q   <= ncols_i;
                            row_cnt_q <= 8'd0;
                            col_cnt_q <= 8'd0;
                            err_q     <= 1'b0;
                            tx_en_q   <= 1'b1;
                            state_q   <= LAUNCH;
                        end else begin
                            state_q   <= FIN;
                        end
                    end
                end
                LAUNCH: begin
                    if (TX_LATENCY == 1) begin
                        state_q <= STREAM;
                    end else begin
                        wait_q  <= WAIT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_q == 4'd0) state_q <= STREAM;
                    else                wait_q  <= wait_q - 4'd1;
                end
                STREAM: begin
                    if (!emit) begin
                        err_q   <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        pix_valid_q <= 1'b1;
                        pix_data_q  <= tx_dout_i;
                        row_q       <= row_cnt_q;
                        col_q       <= col_cnt_q;
                        sof_q       <= (row_cnt_q == 8'd0) && (col_cnt_q == 8'd0);
                        eol_q       <= row_end;
                        eof_q       <= last_px;
                        if (row_end) begin
                            col_cnt_q <= 8'd0;
                            row_cnt_q <= row_cnt_q + 8'd1;
                        end else begin
                            col_cnt_q <= col_cnt_q + 8'd1;
                        end
                        if (last_px) state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IO_FRAME_SINK_CKSUM_EN
    logic [7:0] s1_q, s2_q, s1_d, s2_d;
    logic [8:0] s1_sum, s2_sum;
    logic       ck_clr, ck_upd;

    assign ck_clr = (state_q == IDLE) && accept;
    assign ck_upd = (state_q == STREAM) && emit;

    // Running sums stay in 0..254, so one conditional subtract is an exact mod 255.
    always_comb begin
        s1_sum = {1'b0, s1_q} + {1'b0, tx_dout_i};
        s1_d   = (s1_sum >= 9'd255) ? 8'(s1_sum - 9'd255) : s1_sum[7:0];
        s2_sum = {1'b0, s2_q} + {1'b0, s1_d};
        s2_d   = (s2_sum >= 9'd255) ? 8'(s2_sum - 9'd255) : s2_sum[7:0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_q <= 8'd0;
            s2_q <= 8'd0;
        end else if (ck_clr) begin
            s1_q <= 8'd0;
            s2_q <= 8'd0;
        end else if (ck_upd) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign cksum_o = {s2_q, s1_q};
`else
    assign cksum_o = 16'h0000;
`endif

    assign tx_en_o     = tx_en_q;
    assign busy_o      = busy_q;
    assign pix_valid_o = pix_valid_q;
    assign pix_data_o  = pix_data_q;
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign eof_o       = eof_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_io_frame_sink.sv
// Bench for io_frame_sink: per-cycle expectation tables built from frame rules, plus a tx controller stand-in.
module tb_io_frame_sink;
    localparam int L  = 2;
    localparam int NC = 1024;

    logic        clk = 1'b0;
    logic        rstn, start, tx_busy;
    logic [7:0]  nrows, ncols, tx_dout;
    logic        tx_en, busy, pix_valid, sof, eol, eof, done, err;
    logic [7:0]  pix_data, row, col;
    logic [15:0] cksum;

    io_frame_sink #(.TX_LATENCY(L)) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .nrows_i(nrows), .ncols_i(ncols),
        .tx_dout_i(tx_dout), .tx_busy_i(tx_busy), .tx_en_o(tx_en), .busy_o(busy),
        .pix_valid_o(pix_valid), .pix_data_o(pix_data), .row_o(row), .col_o(col),
        .sof_o(sof), .eol_o(eol), .eof_o(eof), .done_o(done), .err_o(err), .cksum_o(cksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected outputs, indexed by the posedge after which they are visible.
    bit          e_txen[NC], e_busy[NC], e_vld[NC], e_sof[NC], e_eol[NC], e_eof[NC], e_done[NC], e_err[NC];
    logic [7:0]  e_dat[NC], e_row[NC], e_col[NC];
    logic [15:0] e_ck[NC];

    logic [7:0]  img[256];
    int          cur_n = 0;
    int          fault = -1;
    int          npix = 0, nen = 0, ndone = 0, nsof = 0, last_done = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic plan_frame(input int s, input int nr, input int nc, input int u, output int d);
        int n, m, e, c, s1, s2;
        n = nr * nc;
        if (n == 0) begin
            d = s + 1;
        end else begin
            e_txen[s] = 1'b1;
            m = (u >= 0) ? u + 1 : n;
            e = (u >= 0) ? u : n;
            d = s + L + m + 1;
            for (int i = s; i < NC; i++) begin
                e_err[i] = 1'b0;
                e_ck[i]  = 16'h0;
            end
            s1 = 0;
            s2 = 0;
            for (int k = 0; k < e; k++) begin
                c = s + 1 + L + k;
                e_vld[c] = 1'b1;
                e_dat[c] = img[k];
                e_row[c] = 8'(k / nc);
                e_col[c] = 8'(k % nc);
                e_sof[c] = (k == 0);
                e_eol[c] = ((k % nc) == nc - 1);
                e_eof[c] = (k == n - 1);
`ifdef IO_FRAME_SINK_CKSUM_EN
                s1 = (s1 + int'(img[k])) % 255;
                s2 = (s2 + s1) % 255;
                for (int i = c; i < NC; i++) e_ck[i] = {8'(s2), 8'(s1)};
`endif
            end
            if (u >= 0) for (int i = s + 1 + L + u; i < NC; i++) e_err[i] = 1'b1;
        end
        for (int i = s; i <= d; i++) e_busy[i] = 1'b1;
        e_done[d] = 1'b1;
    endtask

    task automatic clear_from(input int c0);
        for (int i = c0; i < NC; i++) begin
            e_txen[i] = 0; e_busy[i] = 0; e_vld[i] = 0; e_sof[i] = 0; e_eol[i] = 0;
            e_eof[i] = 0; e_done[i] = 0; e_err[i] = 0; e_ck[i] = 16'h0;
        end
    endtask

    task automatic launch(input int nr, input int nc, input int u, output int s, output int d);
        @(posedge clk); #1;
        nrows = 8'(nr); ncols = 8'(nc); start = 1'b1;
        cur_n = nr * nc; fault = u;
        s = cyc + 1;
        plan_frame(s, nr, nc, u, d);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(posedge clk);
        #1;
    endtask

    // Stand-in for io_tx_controller: byte k is stable at edge en_edge+L+k.
    bit en_seen = 1'b0;
    int en_edge = -100000;
    int drv_k;
    always @(negedge clk) en_seen = tx_en;
    initial begin
        tx_dout = 8'h00;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (en_seen) en_edge = cyc;
            drv_k   = cyc + 1 - en_edge - L;
            tx_busy = (drv_k >= 0) && (drv_k < cur_n) && !(fault >= 0 && drv_k >= fault);
            tx_dout = (drv_k >= 0 && drv_k < cur_n) ? img[drv_k] : 8'hEE;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc < NC) begin
                chk("tx_en", 32'(tx_en), 32'(e_txen[cyc]));
                chk("busy", 32'(busy), 32'(e_busy[cyc]));
                chk("pix_valid", 32'(pix_valid), 32'(e_vld[cyc]));
                chk("sof", 32'(sof), 32'(e_sof[cyc]));
                chk("eol", 32'(eol), 32'(e_eol[cyc]));
                chk("eof", 32'(eof), 32'(e_eof[cyc]));
                chk("done", 32'(done), 32'(e_done[cyc]));
                chk("err", 32'(err), 32'(e_err[cyc]));
                chk("cksum", 32'(cksum), 32'(e_ck[cyc]));
                if (e_vld[cyc]) begin
                    chk("pix_data", 32'(pix_data), 32'(e_dat[cyc]));
                    chk("row", 32'(row), 32'(e_row[cyc]));
                    chk("col", 32'(col), 32'(e_col[cyc]));
                end
            end
            if (pix_valid) npix++;
            if (tx_en) nen++;
            if (sof) nsof++;
            if (done) begin
                ndone++;
                last_done = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s, d, s2, d2, p0, n0, dn0, sof0, cr;
        logic [15:0] ck_exp;
        rstn = 1'b0; start = 1'b0; nrows = 8'd0; ncols = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cksum", 32'(cksum), 32'd0);
        rstn = 1'b1;

        // 2x2 frame 01..04
        for (int k = 0; k < 4; k++) img[k] = 8'(k + 1);
        p0 = npix;
        launch(2, 2, -1, s, d);
        wait_until(d + 2);
        chk("pix_count_2x2", 32'(npix - p0), 32'd4);
        chk("done_cycle_2x2", 32'(last_done), 32'(s + 3 + 4));
`ifdef IO_FRAME_SINK_CKSUM_EN
        ck_exp = 16'h140A;
`else
        ck_exp = 16'h0000;
`endif
        chk("cksum_2x2", 32'(cksum), 32'(ck_exp));

        // zero-height frame
        p0 = npix; n0 = nen;
        launch(0, 5, -1, s, d);
        wait_until(d + 2);
        chk("pix_count_zero", 32'(npix - p0), 32'd0);
        chk("tx_en_count_zero", 32'(nen - n0), 32'd0);
        chk("done_cycle_zero", 32'(last_done), 32'(s + 1));

        // 3x5 frame with random data
        for (int k = 0; k < 15; k++) img[k] = 8'($urandom_range(0, 255));
        p0 = npix;
        launch(3, 5, -1, s, d);
        wait_until(d + 2);
        chk("pix_count_3x5", 32'(npix - p0), 32'd15);

        // 4x4 with tx_busy dropping at pixel 6
        for (int k = 0; k < 16; k++) img[k] = 8'(8'h10 + k);
        p0 = npix;
        launch(4, 4, 6, s, d);
        wait_until(d + 2);
        chk("pix_count_underrun", 32'(npix - p0), 32'd6);
        chk("err_after_underrun", 32'(err), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);

        // reset during pixel 3 of a 4x4 frame
        dn0 = ndone;
        launch(4, 4, -1, s, d);
        wait_until(s + 1 + L + 3);
        rstn = 1'b0;
        cr = cyc;
        clear_from(cr);
        #1;
        chk("rst_mid_valid", 32'(pix_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_row", 32'(row), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_done", 32'(ndone - dn0), 32'd0);

        // 1x1 frame after reset
        img[0] = 8'hA5;
        launch(1, 1, -1, s, d);
        wait_until(d + 2);
        chk("done_1x1", 32'(last_done), 32'(s + L + 1 + 1));
`ifdef IO_FRAME_SINK_CKSUM_EN
        ck_exp = 16'hA5A5;
`else
        ck_exp = 16'h0000;
`endif
        chk("cksum_1x1", 32'(cksum), 32'(ck_exp));

        // start held high across two 1x3 frames
        img[0] = 8'h07; img[1] = 8'h08; img[2] = 8'h09;
        p0 = npix; sof0 = nsof;
        @(posedge clk); #1;
        nrows = 8'd1; ncols = 8'd3; start = 1'b1;
        cur_n = 3; fault = -1;
        s = cyc + 1;
        plan_frame(s, 1, 3, -1, d);
        s2 = d + 1;
        plan_frame(s2, 1, 3, -1, d2);
        wait_until(s2);
        start = 1'b0;
        wait_until(d2 + 3);
        chk("pix_count_held", 32'(npix - p0), 32'd6);
        chk("sof_count_held", 32'(nsof - sof0), 32'd2);
        chk("second_start_gap", 32'(s2 - d), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_frame_sink.md
# io_frame_sink

Receiving end of the `io_tx_controller` byte stream. On `start`, it pulses the tx controller's `en` and waits a fixed pipeline latency. It then samples `nrows*ncols` gapless bytes from `io_dout` and re-presents each one with row/column coordinates and frame markers. It replaces bench-side capture loops and feeds on-chip consumers such as a result checker or an off-chip link.

## Interface
Parameters:
- `TX_LATENCY`, default 2: cycles from the posedge where the tx controller samples `tx_en=1` to the posedge where the first valid byte is sampled; legal 1..15.

Ports:
- `clk` input 1: clock, all logic on posedge.
- `rstn` input 1: reset, asynchronous, active-low.
- `start` input 1: frame request, sampled in IDLE only.
- `nrows` input 8: frame height, latched on accepted `start`.
- `ncols` input 8: frame width, latched on accepted `start`.
- `tx_dout` input 8: byte stream from `io_tx_controller.dout`.
- `tx_busy` input 1: `io_tx_controller.busy`.
- `tx_en` output 1: one-cycle launch pulse to `io_tx_controller.en`.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `pix_valid` output 1: one cycle per captured byte.
- `pix_data` output 8: captured byte.
- `row` output 8: row index of `pix_data`.
- `col` output 8: column index of `pix_data`.
- `sof` output 1: first pixel of the frame.
- `eol` output 1: last pixel of a row.
- `eof` output 1: last pixel of the frame.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: sticky stream-underrun flag.
- `cksum` output 16: Fletcher-16 checksum of the frame (see Configuration).

## Operation
- States: IDLE, LAUNCH, WAIT, STREAM, FIN.
- IDLE → LAUNCH on `start=1` when `nrows` and `ncols` are both nonzero.
  - The accepting edge latches sizes, clears `err` and the checksum, and zeroes the row/col counters.
- IDLE with `start=1` and either size 0: go straight to FIN.
  - `tx_en` is never driven and no pixels are produced.
- LAUNCH: `tx_en=1` for exactly one cycle, then WAIT.
- WAIT: a 4-bit counter runs `TX_LATENCY-1` further cycles, then STREAM.
- STREAM: samples `tx_dout` every posedge, with no gaps.
  - Each sample produces a `pix_valid` cycle carrying `row`/`col`.
  - `col` increments and wraps to 0 at `ncols-1`, at which point `row` increments.
  - The sample at `row=nrows-1`, `col=ncols-1` is the last; next state is FIN.
- Markers: `sof` when row=col=0; `eol` when col=ncols-1; `eof` when it is the last pixel.
  - Markers are only valid when `pix_valid=1` and are 0 otherwise.
- Underrun: `tx_busy=0` sampled in STREAM before the last pixel sets `err=1`.
  - The current byte is not emitted and the state goes to FIN.
- FIN: `done=1` for one cycle, `busy` drops on the same edge, then IDLE.
- `start` outside IDLE is ignored.
- Counter arithmetic: row/col are 8-bit; the last-pixel compare uses latched sizes minus 1, which cannot underflow because zero sizes never enter STREAM.

## Timing
- Reset values: every output is 0; `cksum=0`; state IDLE.
- Reset asserted mid-frame aborts immediately. No `done` is generated and `err` is cleared.
- `start` is sampled at posedge t.
  - `tx_en` and `busy` are high after t.
  - `tx_en` is low again after t+1.
- First byte is sampled at posedge t+1+`TX_LATENCY`.
  - `pix_valid`, `pix_data`, `row`, `col` and markers are registered and visible after that edge.
  - Last pixel visible after edge t+`TX_LATENCY`+N, where N=nrows*ncols.
  - `done` is high in the following cycle; `busy` is low after the `done` cycle.
- Latency from `tx_dout` sample to `pix_data` output: 1 cycle.
- `cksum` is registered and is final in the `done` cycle. It holds its value until the next accepted `start`.
- A new `start` may be accepted the cycle after `done`, i.e. back-to-back frames with one idle cycle.

## Configuration
- `IO_FRAME_SINK_CKSUM_EN` defined:
  - Fletcher-16 over emitted bytes in order: s1=(s1+b) mod 255, s2=(s2+s1) mod 255, `cksum`={s2,s1}.
  - Both sums are cleared on accepted `start`.
- Not defined: checksum logic is absent and `cksum` is tied to 16'h0000.

## Test plan
- 2x2 frame, SRAM bytes 01,02,03,04, `TX_LATENCY=2` → `tx_en` high 1 cycle after start.
  - Exactly 4 `pix_valid`, with (row,col)=(0,0),(0,1),(1,0),(1,1) and data 01..04.
  - `sof` on the 1st pixel, `eol` on the 2nd and 4th, `eof` on the 4th.
  - `done` the next cycle; `cksum=16'h140A` with the macro, 0 without.
- 128x128 frame of a known image through `io_rx_controller` → SRAM → `io_tx_controller` → this block.
  - 16384 pixels, bitwise equal to the input.
  - `done` at cycle start+3+16384; `err=0`.
- `start` with `nrows=0`, `ncols=5` → no `tx_en`; `done` 2 cycles after start; `pix_valid` never asserts.
- 4x4 frame with `tx_busy` forced low at pixel 6 → `err=1`; 6 pixels emitted; `done` pulse; `err` holds until the next start clears it.
- Reset pulled low at pixel 3 of a 4x4 frame → all outputs 0 immediately; no `done`.
  - A subsequent 1x1 frame completes normally.
- `start` held high continuously through a 1x3 frame → exactly one frame, then a second frame accepted the cycle after `done`; `sof` repeats on its first pixel.
